// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl
// Data-memory initiator between the core's load/store stage and four
// byte-lane block RAMs (lane i holds byte i of a little-endian word).
// Takes one load/store request at a time, drives the lane RAMs for exactly
// one ACCESS cycle (the RAMs act on that cycle's falling edge), then returns
// an extended load result or an error through a valid/ready response.
//
// Ports:
//   CLK, RSTN                 clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY       request handshake
//   REQ_WE, REQ_ADDR,
//   REQ_SIZE, REQ_UNSIGNED,
//   REQ_WDATA                 request fields (store data right-aligned)
//   RESP_VALID/RESP_READY     response handshake
//   RESP_RDATA, RESP_ERR      load result / error flag
//   MEM_W_ADDR, MEM_R_ADDR    shared lane byte address (word = [AW-1:2])
//   MEM_WE, MEM_RE            per-lane write / read enables
//   MEM_DIN, MEM_DOUT         lane write / read bytes, lane i on [8i+7:8i]
module dmem_lane_ctrl #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [31:0]           REQ_ADDR,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_UNSIGNED,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
    output logic [31:0]           RESP_RDATA,
    output logic                  RESP_ERR,
    output logic [ADDR_WIDTH-1:0] MEM_W_ADDR,
    output logic [ADDR_WIDTH-1:0] MEM_R_ADDR,
    output logic [3:0]            MEM_WE,
    output logic [3:0]            MEM_RE,
    output logic [31:0]           MEM_DIN,
    input  logic [31:0]           MEM_DOUT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            mem_we_q, mem_we_d;
    logic [3:0]            mem_re_q, mem_re_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_din_q, mem_din_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            offset_q, offset_d;
    logic                  unsigned_q, unsigned_d;

    logic                  req_illegal;
    logic [3:0]            req_lane_mask;
    logic [31:0]           req_din;
    logic [31:0]           lane_shifted;
    logic [31:0]           load_result;

    // Request decode: legality, lane mask and lane-replicated store data.
    always_comb begin
        req_illegal   = |REQ_ADDR[31:ADDR_WIDTH];
        req_lane_mask = 4'b0000;
        req_din       = REQ_WDATA;
        case (REQ_SIZE)
            2'b00: begin
                req_lane_mask = 4'b0001 << REQ_ADDR[1:0];
                req_din       = {4{REQ_WDATA[7:0]}};
            end
            2'b01: begin
                req_lane_mask = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
                req_din       = {2{REQ_WDATA[15:0]}};
                if (REQ_ADDR[0]) begin
                    req_illegal = 1'b1;
                end
            end
            2'b10: begin
                req_lane_mask = 4'b1111;
                if (REQ_ADDR[1:0] != 2'b00) begin
                    req_illegal = 1'b1;
                end
            end
            default: begin
                req_illegal = 1'b1;
            end
        endcase
    end

    // Legal halves/words are naturally aligned, so shifting by the byte
    // offset brings the selected lanes down to bit 0 for every size.
    always_comb begin
        lane_shifted = MEM_DOUT >> {offset_q, 3'b000};
        case (size_q)
            2'b00:   load_result = unsigned_q ? {24'h000000, lane_shifted[7:0]}
                                              : {{24{lane_shifted[7]}}, lane_shifted[7:0]};
            2'b01:   load_result = unsigned_q ? {16'h0000, lane_shifted[15:0]}
                                              : {{16{lane_shifted[15]}}, lane_shifted[15:0]};
            default: load_result = MEM_DOUT;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_we_d     = mem_we_q;
        mem_re_d     = mem_re_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        size_d       = size_q;
        offset_d     = offset_q;
        unsigned_d   = unsigned_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    size_d     = REQ_SIZE;
                    offset_d   = REQ_ADDR[1:0];
                    unsigned_d = REQ_UNSIGNED;
                    if (req_illegal) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = REQ_ADDR[ADDR_WIDTH-1:0];
                        if (REQ_WE) begin
                            mem_we_d  = req_lane_mask;
                            mem_din_d = req_din;
                        end else begin
                            mem_re_d = req_lane_mask;
                        end
                    end
                end
            end
            ACCESS: begin
                // A nonzero read mask is what marks this access as a load.
                state_d      = RESP;
                mem_we_d     = 4'b0000;
                mem_re_d     = 4'b0000;
                mem_din_d    = 32'h0;
                resp_err_d   = 1'b0;
                resp_rdata_d = (mem_re_q != 4'b0000) ? load_result : 32'h0;
            end
            RESP: begin
                if (RESP_READY) begin
                    state_d      = IDLE;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= IDLE;
            mem_we_q     <= 4'b0000;
            mem_re_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_din_q    <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            size_q       <= 2'b00;
            offset_q     <= 2'b00;
            unsigned_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            unsigned_q   <= unsigned_d;
        end
    end

    // REQ_READY is gated by RSTN so it is low for the whole reset pulse.
    assign REQ_READY  = (state_q == IDLE) && RSTN;
    assign RESP_VALID = (state_q == RESP);
    assign RESP_RDATA = resp_rdata_q;
    assign RESP_ERR   = resp_err_q;
    assign MEM_W_ADDR = mem_addr_q;
    assign MEM_R_ADDR = mem_addr_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_RE     = mem_re_q;
    assign MEM_DIN    = mem_din_q;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// tb_dmem_lane_ctrl
// Directed bench for dmem_lane_ctrl with a four-lane byte RAM model that
// writes/reads on the falling clock edge, zero-initialised.
module tb_dmem_lane_ctrl;

    localparam int AW = 13;

    logic          CLK;
    logic          RSTN;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WE;
    logic [31:0]   REQ_ADDR;
    logic [1:0]    REQ_SIZE;
    logic          REQ_UNSIGNED;
    logic [31:0]   REQ_WDATA;
    logic          RESP_VALID;
    logic          RESP_READY;
    logic [31:0]   RESP_RDATA;
    logic          RESP_ERR;
    logic [AW-1:0] MEM_W_ADDR;
    logic [AW-1:0] MEM_R_ADDR;
    logic [3:0]    MEM_WE;
    logic [3:0]    MEM_RE;
    logic [31:0]   MEM_DIN;
    logic [31:0]   MEM_DOUT = '0;

    logic [7:0]    laneRam [4][2048] = '{default: '0};

    int            assertCount = 0;
    int            failCount = 0;
    int            bothCount = 0;

    logic [3:0]    obsWe;
    logic [3:0]    obsRe;
    logic [31:0]   obsDin;
    logic [AW-1:0] obsWAddr;
    logic [AW-1:0] obsRAddr;
    logic [3:0]    obsEnSeen;
    logic [31:0]   obsRdata;
    logic          obsErr;
    int            obsLatency;

    dmem_lane_ctrl #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR),
        .REQ_SIZE(REQ_SIZE),
        .REQ_UNSIGNED(REQ_UNSIGNED),
        .REQ_WDATA(REQ_WDATA),
        .RESP_VALID(RESP_VALID),
        .RESP_READY(RESP_READY),
        .RESP_RDATA(RESP_RDATA),
        .RESP_ERR(RESP_ERR),
        .MEM_W_ADDR(MEM_W_ADDR),
        .MEM_R_ADDR(MEM_R_ADDR),
        .MEM_WE(MEM_WE),
        .MEM_RE(MEM_RE),
        .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Lane RAMs act on the falling edge, in the middle of the ACCESS cycle.
    always @(negedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (MEM_WE[i]) laneRam[i][MEM_W_ADDR[AW-1:2]] <= MEM_DIN[8*i +: 8];
            if (MEM_RE[i]) MEM_DOUT[8*i +: 8] <= laneRam[i][MEM_R_ADDR[AW-1:2]];
        end
    end

    always @(negedge CLK) begin
        if ((MEM_WE != 4'b0000) && (MEM_RE != 4'b0000)) bothCount <= bothCount + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request, records what the lane port did and the response.
    // When autoRelease is 0 the response is left pending for the caller.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata, input bit autoRelease);
        int waitCycles;
        waitCycles = 0;
        while (!REQ_READY && waitCycles < 10) begin
            @(posedge CLK); #1;
            waitCycles++;
        end
        checkOutput("req_ready_idle", {31'b0, REQ_READY}, 32'd1);
        REQ_VALID    = 1'b1;
        REQ_WE       = we;
        REQ_ADDR     = addr;
        REQ_SIZE     = size;
        REQ_UNSIGNED = uns;
        REQ_WDATA    = wdata;
        @(posedge CLK); #1;
        REQ_VALID  = 1'b0;
        REQ_WE     = 1'b0;
        REQ_ADDR   = 32'hFFFF_FFFF;
        REQ_WDATA  = 32'h0;
        obsLatency = 1;
        obsWe      = MEM_WE;
        obsRe      = MEM_RE;
        obsDin     = MEM_DIN;
        obsWAddr   = MEM_W_ADDR;
        obsRAddr   = MEM_R_ADDR;
        obsEnSeen  = MEM_WE | MEM_RE;
        while (!RESP_VALID && obsLatency < 6) begin
            @(posedge CLK); #1;
            obsLatency++;
            obsEnSeen = obsEnSeen | MEM_WE | MEM_RE;
        end
        obsRdata = RESP_RDATA;
        obsErr   = RESP_ERR;
        if (autoRelease) begin
            RESP_READY = 1'b1;
            @(posedge CLK); #1;
            RESP_READY = 1'b0;
        end
    endtask

    task automatic checkResponse(input string tag, input logic [31:0] expRdata, input logic expErr,
                                 input int expLatency);
        checkOutput({tag, ".rdata"}, obsRdata, expRdata);
        checkOutput({tag, ".err"}, {31'b0, obsErr}, {31'b0, expErr});
        checkOutput({tag, ".latency"}, obsLatency, expLatency);
    endtask

    initial begin
        RSTN         = 1'b0;
        REQ_VALID    = 1'b0;
        REQ_WE       = 1'b0;
        REQ_ADDR     = 32'h0;
        REQ_SIZE     = 2'b00;
        REQ_UNSIGNED = 1'b0;
        REQ_WDATA    = 32'h0;
        RESP_READY   = 1'b0;

        #2;
        checkOutput("rst.req_ready", {31'b0, REQ_READY}, 32'd0);
        checkOutput("rst.resp_valid", {31'b0, RESP_VALID}, 32'd0);
        checkOutput("rst.resp_err", {31'b0, RESP_ERR}, 32'd0);
        checkOutput("rst.resp_rdata", RESP_RDATA, 32'h0);
        checkOutput("rst.mem_we", {28'b0, MEM_WE}, 32'h0);
        checkOutput("rst.mem_re", {28'b0, MEM_RE}, 32'h0);
        checkOutput("rst.mem_w_addr", {19'b0, MEM_W_ADDR}, 32'h0);
        checkOutput("rst.mem_r_addr", {19'b0, MEM_R_ADDR}, 32'h0);
        checkOutput("rst.mem_din", MEM_DIN, 32'h0);
        #10 RSTN = 1'b1;
        #1;
        checkOutput("rst.req_ready_after", {31'b0, REQ_READY}, 32'd1);
        @(posedge CLK); #1;

        // Word store then word load.
        applyStimulus(1'b1, 32'h100, 2'b10, 1'b0, 32'h11223344, 1'b1);
        checkOutput("sw.mem_we", {28'b0, obsWe}, 32'hF);
        checkOutput("sw.mem_re", {28'b0, obsRe}, 32'h0);
        checkOutput("sw.mem_din", obsDin, 32'h11223344);
        checkOutput("sw.mem_w_addr", {19'b0, obsWAddr}, 32'h100);
        checkResponse("sw", 32'h0, 1'b0, 2);
        applyStimulus(1'b0, 32'h100, 2'b10, 1'b1, 32'h0, 1'b1);
        checkOutput("lw.mem_re", {28'b0, obsRe}, 32'hF);
        checkOutput("lw.mem_we", {28'b0, obsWe}, 32'h0);
        checkOutput("lw.mem_r_addr", {19'b0, obsRAddr}, 32'h100);
        checkResponse("lw", 32'h11223344, 1'b0, 2);

        // Byte store to lane 3, signed/unsigned byte loads, shifted reads.
        applyStimulus(1'b1, 32'h103, 2'b00, 1'b0, 32'h12345680, 1'b1);
        checkOutput("sb.mem_we", {28'b0, obsWe}, 32'h8);
        checkOutput("sb.mem_din", obsDin, 32'h80808080);
        checkResponse("sb", 32'h0, 1'b0, 2);
        applyStimulus(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 1'b1);
        checkOutput("lb.mem_re", {28'b0, obsRe}, 32'h8);
        checkResponse("lb", 32'hFFFFFF80, 1'b0, 2);
        applyStimulus(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 1'b1);
        checkResponse("lbu", 32'h00000080, 1'b0, 2);
        applyStimulus(1'b0, 32'h101, 2'b00, 1'b1, 32'h0, 1'b1);
        checkOutput("lbu1.mem_re", {28'b0, obsRe}, 32'h2);
        checkResponse("lbu1", 32'h00000033, 1'b0, 2);
        applyStimulus(1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 1'b1);
        checkResponse("lh_hi", 32'hFFFF8022, 1'b0, 2);

        // Half store to upper lanes, half/byte/word loads around it.
        applyStimulus(1'b1, 32'h22, 2'b01, 1'b0, 32'hAAAABEEF, 1'b1);
        checkOutput("sh.mem_we", {28'b0, obsWe}, 32'hC);
        checkOutput("sh.mem_din", obsDin, 32'hBEEFBEEF);
        checkResponse("sh", 32'h0, 1'b0, 2);
        applyStimulus(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 1'b1);
        checkOutput("lh.mem_re", {28'b0, obsRe}, 32'hC);
        checkResponse("lh", 32'hFFFFBEEF, 1'b0, 2);
        applyStimulus(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 1'b1);
        checkResponse("lhu", 32'h0000BEEF, 1'b0, 2);
        applyStimulus(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, 1'b1);
        checkOutput("lb0.mem_re", {28'b0, obsRe}, 32'h1);
        checkResponse("lb0", 32'h0, 1'b0, 2);
        applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1);
        checkResponse("lw20", 32'hBEEF0000, 1'b0, 2);

        // Illegal requests: no lane activity, error response one edge later.
        applyStimulus(1'b0, 32'h101, 2'b10, 1'b0, 32'h0, 1'b1);
        checkOutput("err_lw_mis.enables", {28'b0, obsEnSeen}, 32'h0);
        checkResponse("err_lw_mis", 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 1'b1);
        checkOutput("err_size.enables", {28'b0, obsEnSeen}, 32'h0);
        checkResponse("err_size", 32'h0, 1'b1, 1);
        applyStimulus(1'b1, 32'h4000, 2'b00, 1'b0, 32'h55, 1'b1);
        checkOutput("err_range.enables", {28'b0, obsEnSeen}, 32'h0);
        checkResponse("err_range", 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 1'b1);
        checkResponse("err_lh_mis", 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 32'h8000_0000, 2'b00, 1'b1, 32'h0, 1'b1);
        checkResponse("err_hibit", 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1);
        checkResponse("no_alias", 32'h0, 1'b0, 2);

        // Response backpressure with an ignored request during the hold.
        applyStimulus(1'b1, 32'h1F0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b1);
        checkResponse("sw_cafe", 32'h0, 1'b0, 2);
        applyStimulus(1'b0, 32'h1F0, 2'b10, 1'b0, 32'h0, 1'b0);
        checkResponse("hold", 32'hCAFEF00D, 1'b0, 2);
        for (int h = 0; h < 3; h++) begin
            if (h == 0) begin
                REQ_VALID = 1'b1;
                REQ_WE    = 1'b1;
                REQ_ADDR  = 32'h1F0;
                REQ_SIZE  = 2'b10;
                REQ_WDATA = 32'h0;
            end
            @(posedge CLK); #1;
            REQ_VALID = 1'b0;
            REQ_WE    = 1'b0;
            checkOutput("hold.resp_valid", {31'b0, RESP_VALID}, 32'd1);
            checkOutput("hold.resp_rdata", RESP_RDATA, 32'hCAFEF00D);
            checkOutput("hold.resp_err", {31'b0, RESP_ERR}, 32'd0);
            checkOutput("hold.req_ready", {31'b0, REQ_READY}, 32'd0);
            checkOutput("hold.mem_we", {28'b0, MEM_WE}, 32'h0);
        end
        RESP_READY = 1'b1;
        @(posedge CLK); #1;
        RESP_READY = 1'b0;
        checkOutput("hold.release_ready", {31'b0, REQ_READY}, 32'd1);
        checkOutput("hold.release_valid", {31'b0, RESP_VALID}, 32'd0);
        applyStimulus(1'b0, 32'h1F0, 2'b10, 1'b0, 32'h0, 1'b1);
        checkResponse("hold_after", 32'hCAFEF00D, 1'b0, 2);

        // Reset in the middle of a load's ACCESS cycle.
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_ADDR  = 32'h100;
        REQ_SIZE  = 2'b10;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        checkOutput("mid.pre_re", {28'b0, MEM_RE}, 32'hF);
        #2 RSTN = 1'b0;
        #1;
        checkOutput("mid.mem_re", {28'b0, MEM_RE}, 32'h0);
        checkOutput("mid.mem_we", {28'b0, MEM_WE}, 32'h0);
        checkOutput("mid.resp_valid", {31'b0, RESP_VALID}, 32'd0);
        checkOutput("mid.req_ready", {31'b0, REQ_READY}, 32'd0);
        checkOutput("mid.mem_r_addr", {19'b0, MEM_R_ADDR}, 32'h0);
        checkOutput("mid.mem_w_addr", {19'b0, MEM_W_ADDR}, 32'h0);
        checkOutput("mid.mem_din", MEM_DIN, 32'h0);
        checkOutput("mid.resp_rdata", RESP_RDATA, 32'h0);
        #10 RSTN = 1'b1;
        #1;
        checkOutput("mid.release_ready", {31'b0, REQ_READY}, 32'd1);
        checkOutput("mid.release_valid", {31'b0, RESP_VALID}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            checkOutput("mid.no_resp", {31'b0, RESP_VALID}, 32'd0);
        end
        applyStimulus(1'b0, 32'h1F0, 2'b10, 1'b0, 32'h0, 1'b1);
        checkResponse("post_rst", 32'hCAFEF00D, 1'b0, 2);

        checkOutput("we_re_exclusive", bothCount, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
